// File: rtl/ppm_decoder.sv
// ppm_decoder: turns a single-wire RC PPM stream into eight channel pulse
// widths in whole microseconds. Channel values are collected in a shadow
// bank and committed to the outputs all at once when a complete frame is
// closed by a sync gap. Loss of signal drives every channel to 0.
module ppm_decoder #(
  parameter int US_DIV      = 50,
  parameter int SYNC_MIN_US = 3000,
  parameter int CH_MIN_US   = 800,
  parameter int CH_MAX_US   = 2200,
  parameter int TIMEOUT_US  = 25000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        En,
  input  logic        PPM_In,
  output logic [15:0] Channel1,
  output logic [15:0] Channel2,
  output logic [15:0] Channel3,
  output logic [15:0] Channel4,
  output logic [15:0] Channel5,
  output logic [15:0] Channel6,
  output logic [15:0] Channel7,
  output logic [15:0] Channel8,
  output logic        Frame_Strobe,
  output logic        Frame_Valid,
  output logic        Signal_Lost
);

  localparam int          PW        = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(US_DIV - 1);
  localparam logic [15:0] SYNC_MIN  = 16'(SYNC_MIN_US);
  localparam logic [15:0] CH_MIN    = 16'(CH_MIN_US);
  localparam logic [15:0] CH_MAX    = 16'(CH_MAX_US);
  localparam logic [15:0] TIMEOUT   = 16'(TIMEOUT_US);

  typedef enum logic {HUNT = 1'b0, CAPTURE = 1'b1} state_t;

  // Input stage: two synchronizer flops plus the previous synchronized value.
  logic [1:0]    sync_q;
  logic          ppm_prev_q;
  logic          edge_s;

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   us_cnt_q, us_cnt_d;
  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   shadow_q [8];
  logic [15:0]   shadow_d [8];
  logic [15:0]   chan_q [8];
  logic [15:0]   chan_d [8];
  logic          strobe_q, strobe_d;
  logic          valid_q, valid_d;
  logic          lost_q, lost_d;

  logic          is_sync_s, is_ch_s, timeout_s;

  // us_cnt holds the interval since the previous edge at the moment an edge arrives.
  assign edge_s    = sync_q[1] & ~ppm_prev_q;
  assign is_sync_s = (us_cnt_q >= SYNC_MIN);
  assign is_ch_s   = (us_cnt_q >= CH_MIN) && (us_cnt_q <= CH_MAX);
  assign timeout_s = (us_cnt_q >= TIMEOUT);

  // Next-state logic: timebase, frame FSM, shadow capture and atomic commit.
  always_comb begin
    presc_d  = presc_q;
    us_cnt_d = us_cnt_q;
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    chan_d   = chan_q;
    strobe_d = 1'b0;
    valid_d  = valid_q;
    lost_d   = lost_q;

    // Timebase restarts on every edge so each interval is measured from zero.
    if (edge_s) begin
      presc_d  = '0;
      us_cnt_d = 16'h0000;
    end else if (presc_q == PRE_LAST) begin
      presc_d  = '0;
      us_cnt_d = (us_cnt_q == 16'hFFFF) ? us_cnt_q : us_cnt_q + 16'h0001;
    end else begin
      presc_d  = presc_q + PW'(1);
    end

    // An edge takes priority over a timeout in the same cycle.
    if (edge_s) begin
      case (state_q)
        HUNT: begin
          if (is_sync_s) begin
            state_d = CAPTURE;
            idx_d   = 4'd0;
          end else begin
            state_d = HUNT;
          end
        end
        CAPTURE: begin
          if (is_sync_s && (idx_q == 4'd8)) begin
            chan_d   = shadow_q;
            strobe_d = 1'b1;
            valid_d  = 1'b1;
            lost_d   = 1'b0;
            idx_d    = 4'd0;
          end else if (is_sync_s) begin
            // Short frame: restarting idx discards the partial shadow contents.
            idx_d = 4'd0;
          end else if (is_ch_s && (idx_q < 4'd8)) begin
            shadow_d[idx_q[2:0]] = us_cnt_q;
            idx_d                = idx_q + 4'd1;
          end else begin
            state_d = HUNT;
            idx_d   = 4'd0;
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = 4'd0;
        end
      endcase
    end else if (timeout_s) begin
      // Saturated us_cnt keeps this branch active; repeating it is harmless.
      state_d = HUNT;
      idx_d   = 4'd0;
      chan_d  = '{default: 16'h0000};
      valid_d = 1'b0;
      lost_d  = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

  // All state registers; En=0 holds everything at its reset value.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q     <= 2'b00;
      ppm_prev_q <= 1'b0;
      presc_q    <= '0;
      us_cnt_q   <= 16'h0000;
      state_q    <= HUNT;
      idx_q      <= 4'd0;
      shadow_q   <= '{default: 16'h0000};
      chan_q     <= '{default: 16'h0000};
      strobe_q   <= 1'b0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b1;
    end else if (!En) begin
      sync_q     <= 2'b00;
      ppm_prev_q <= 1'b0;
      presc_q    <= '0;
      us_cnt_q   <= 16'h0000;
      state_q    <= HUNT;
      idx_q      <= 4'd0;
      shadow_q   <= '{default: 16'h0000};
      chan_q     <= '{default: 16'h0000};
      strobe_q   <= 1'b0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], PPM_In};
      ppm_prev_q <= sync_q[1];
      presc_q    <= presc_d;
      us_cnt_q   <= us_cnt_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      chan_q     <= chan_d;
      strobe_q   <= strobe_d;
      valid_q    <= valid_d;
      lost_q     <= lost_d;
    end
  end

  assign Channel1     = chan_q[0];
  assign Channel2     = chan_q[1];
  assign Channel3     = chan_q[2];
  assign Channel4     = chan_q[3];
  assign Channel5     = chan_q[4];
  assign Channel6     = chan_q[5];
  assign Channel7     = chan_q[6];
  assign Channel8     = chan_q[7];
  assign Frame_Strobe = strobe_q;
  assign Frame_Valid  = valid_q;
  assign Signal_Lost  = lost_q;

endmodule

// File: tb/tb_ppm_decoder.sv
// tb_ppm_decoder: directed PPM frames with hand-computed expected outputs.
// Parameters are scaled down (2 clocks per us, limits divided by 10) to keep
// the run short. A rising edge every 2*N+1 clocks measures as N us.
module tb_ppm_decoder;

  localparam int DIV  = 2;
  localparam int SYNC = 300;
  localparam int CMIN = 80;
  localparam int CMAX = 220;
  localparam int TMO  = 2500;
  localparam int GAP  = 400;

  typedef int vec_t [9];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        ppm;
  logic [15:0] ch [8];
  logic        strobe;
  logic        valid;
  logic        lost;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          strobe_cnt = 0;
  int          double_cnt = 0;
  logic        strobe_prev = 1'b0;

  logic [15:0] exp_ch [8];
  int          exp_strobes;
  logic        exp_valid;
  logic        exp_lost;

  vec_t nom  = '{100, 110, 120, 130, 140, 150, 160, 170, 100};
  vec_t alt  = '{80, 220, 150, 90, 200, 110, 180, 120, 0};
  vec_t low  = '{100, 110, 79, 130, 140, 150, 160, 170, 0};
  vec_t high = '{100, 110, 120, 221, 140, 150, 160, 170, 0};

  always #5 clk = ~clk;

  ppm_decoder #(
    .US_DIV(DIV), .SYNC_MIN_US(SYNC), .CH_MIN_US(CMIN),
    .CH_MAX_US(CMAX), .TIMEOUT_US(TMO)
  ) dut (
    .CLK(clk), .RSTn(rst_n), .En(en), .PPM_In(ppm),
    .Channel1(ch[0]), .Channel2(ch[1]), .Channel3(ch[2]), .Channel4(ch[3]),
    .Channel5(ch[4]), .Channel6(ch[5]), .Channel7(ch[6]), .Channel8(ch[7]),
    .Frame_Strobe(strobe), .Frame_Valid(valid), .Signal_Lost(lost)
  );

  // Count strobes and any back-to-back strobe pair.
  always @(negedge clk) begin
    if (strobe) strobe_cnt <= strobe_cnt + 1;
    if (strobe && strobe_prev) double_cnt <= double_cnt + 1;
    strobe_prev <= strobe;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("%s ch%0d", tag, i + 1), {16'h0000, ch[i]}, {16'h0000, exp_ch[i]});
    check_eq({tag, " valid"}, {31'd0, valid}, {31'd0, exp_valid});
    check_eq({tag, " lost"}, {31'd0, lost}, {31'd0, exp_lost});
    check_eq({tag, " strobes"}, strobe_cnt, exp_strobes);
  endtask

  // Rising edge now; next rising edge follows us microseconds later.
  task automatic gap(input int us);
    ppm = 1'b1;
    repeat (5) @(negedge clk);
    ppm = 1'b0;
    repeat (2 * us + 1 - 5) @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v, input int n);
    gap(GAP);
    for (int i = 0; i < n; i++) gap(v[i]);
  endtask

  // Closing sync gap followed by the edge that ends it, then settle.
  task automatic close_frame(input int s);
    gap(s);
    ppm = 1'b1;
    repeat (5) @(negedge clk);
    ppm = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic expect_commit(input vec_t v);
    for (int i = 0; i < 8; i++) exp_ch[i] = v[i][15:0];
    exp_strobes++;
    exp_valid = 1'b1;
    exp_lost  = 1'b0;
  endtask

  task automatic expect_cleared();
    for (int i = 0; i < 8; i++) exp_ch[i] = 16'h0000;
    exp_valid = 1'b0;
    exp_lost  = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    ppm   = 1'b0;
    expect_cleared();
    exp_strobes = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset strobe", {31'd0, strobe}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs("reset");

    // Two nominal frames, one commit each.
    send_frame(nom, 8); close_frame(GAP);
    expect_commit(nom); check_outputs("nominal1");
    send_frame(nom, 8); close_frame(GAP);
    expect_commit(nom); check_outputs("nominal2");

    // Six-channel frame is dropped; outputs hold.
    send_frame(alt, 6); close_frame(GAP);
    check_outputs("short");
    // Full frame with 80/220 boundaries and an exact-minimum sync.
    send_frame(alt, 8); close_frame(SYNC);
    expect_commit(alt); check_outputs("bounds");

    // Range violations never commit.
    send_frame(low, 8); close_frame(GAP);
    check_outputs("ch79");
    send_frame(high, 8); close_frame(GAP);
    check_outputs("ch221");
    send_frame(nom, 9); close_frame(GAP);
    check_outputs("ninth");
    send_frame(nom, 8); close_frame(SYNC - 1);
    check_outputs("sync299");

    // Recover with a good frame.
    send_frame(nom, 8); close_frame(GAP);
    expect_commit(nom); check_outputs("recover");

    // Timeout: still valid just before the limit, cleared just after.
    repeat (2 * TMO - 20) @(negedge clk);
    check_outputs("pre_timeout");
    repeat (40) @(negedge clk);
    expect_cleared(); check_outputs("timeout");
    send_frame(alt, 8); close_frame(GAP);
    expect_commit(alt); check_outputs("after_timeout");

    // En=0 mid-capture returns to reset values.
    send_frame(nom, 4);
    en = 1'b0;
    repeat (10) @(negedge clk);
    expect_cleared(); check_outputs("en_low");
    en = 1'b1;
    for (int i = 4; i < 8; i++) gap(nom[i]);
    close_frame(GAP);
    check_outputs("en_partial");
    send_frame(nom, 8); close_frame(GAP);
    expect_commit(nom); check_outputs("en_full");

    check_eq("no_double_strobe", double_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppm_decoder.md
# ppm_decoder

Decodes a single-wire PPM stream from the RC receiver into eight channel pulse widths in whole microseconds. Its Channel outputs drive the 8-channel PWM generator directly: same 16-bit width and same microsecond unit, with 0 meaning "output off". Values are double-buffered and committed atomically once per complete, validated frame. Loss of signal forces all channels to 0, so the PWM outputs go low.

## Interface
Parameters:
- US_DIV, 50: CLK cycles per microsecond (50 MHz clock).
- SYNC_MIN_US, 3000: minimum rising-to-rising interval, in µs, treated as a frame sync gap.
- CH_MIN_US, 800: minimum valid channel interval, in µs.
- CH_MAX_US, 2200: maximum valid channel interval, in µs.
- TIMEOUT_US, 25000: µs without a rising edge before signal loss is declared.

Ports:
- CLK  in  1  system clock; all logic is clocked on the rising edge.
- RSTn  in  1  reset; one clock, asynchronous, active-low.
- En  in  1  enable; while 0, the block is synchronously held in its reset state.
- PPM_In  in  1  raw asynchronous PPM input.
- Channel1..Channel8  out  16 each  committed pulse width in µs, or 0 for no signal.
- Frame_Strobe  out  1  one-cycle pulse on each commit.
- Frame_Valid  out  1  high while the committed values come from a valid frame.
- Signal_Lost  out  1  high from reset or timeout until the next commit.

## Operation
- **Input stage:** PPM_In passes through a 2-flop synchronizer, then a rising-edge detector that compares the synchronized value against a registered copy.
- **Microsecond timebase:**
  - Prescaler counts 0..US_DIV-1.
  - A 16-bit us_cnt increments on prescaler wrap and saturates at 0xFFFF.
  - On a detected edge: interval = us_cnt, then us_cnt and the prescaler both reset to 0 in the same cycle.
  - Resolution is 1 µs, truncated.
- **States:**
  - HUNT (after reset/En=0):
    - interval >= SYNC_MIN_US → CAPTURE with idx=0.
    - Any other edge is ignored.
  - CAPTURE, evaluated in this priority order:
    - interval >= SYNC_MIN_US and idx==8: commit shadow[0..7] to Channel1..8, pulse Frame_Strobe, set Frame_Valid=1, clear Signal_Lost, restart with idx=0 and stay in CAPTURE.
    - interval >= SYNC_MIN_US and idx<8: short frame. Discard the shadow, set idx=0, stay in CAPTURE. Outputs are unchanged.
    - CH_MIN_US <= interval <= CH_MAX_US and idx<8: shadow[idx]=interval, idx++.
    - Anything else (out of range, or a 9th channel): discard, go to HUNT. Outputs are unchanged.
- **Timeout:** when us_cnt reaches TIMEOUT_US (checked in any state):
  - Set Signal_Lost=1, Frame_Valid=0, and all Channels=0.
  - Go to HUNT.
  - us_cnt keeps saturating; the timeout action repeats harmlessly.
- **Simultaneous edge and timeout in one cycle:** the edge wins; the timeout is not applied.
- **En=0:** all registers take their reset values at the next clock edge and stay there while En=0.
- **Range boundaries:** exact values SYNC_MIN_US, CH_MIN_US and CH_MAX_US are all valid.

## Timing
- **Reset values:** Channel1..8=0, Frame_Strobe=0, Frame_Valid=0, Signal_Lost=1. State=HUNT, idx=0, us_cnt=0, prescaler=0, shadow=0.
- **Edge detection latency:** a PPM_In rising edge is acted on 3 CLK cycles after it is sampled (2 sync + 1 edge register). The latency is constant, so it cancels out of interval measurement.
- **Commit timing:**
  - Channel outputs change in the same cycle that Frame_Strobe is high.
  - Frame_Strobe is high for exactly 1 cycle per commit, never two in consecutive cycles.
  - All eight Channels update in one cycle; the outputs never mix two frames.
- **Timeout timing:** Channels=0 and Signal_Lost=1 appear in the cycle after us_cnt reaches TIMEOUT_US.
- **Hold behaviour:** between commits, the outputs hold their values.
- **Asynchronous reset mid-frame:** every register clears immediately and the partial frame is lost.

## Test plan
- **Reset:** RSTn=0, then release with PPM_In=0 → Channels=0, Frame_Valid=0, Signal_Lost=1, Frame_Strobe=0.
- **Nominal frames:** sync 5000 µs, then intervals 1000,1100,…,1700 µs, then sync; repeat twice → one Frame_Strobe per closing sync, Channel1..8 = 1000..1700, Frame_Valid=1, Signal_Lost=0.
- **Short frame after a good one:** good frame, then a frame of 6 channels plus sync → no strobe, Channels keep their previous values. Next full frame commits.
- **Range violations:**
  - Interval 799 µs mid-frame → HUNT; the next frame is discarded until a sync is seen.
  - Interval 2200 µs is accepted.
  - A 9th channel → HUNT, no commit.
- **Timeout:** after a good frame, hold PPM_In low for 25000 µs → Channels=0, Frame_Valid=0, Signal_Lost=1. A subsequent full frame commits and Signal_Lost clears.
- **En=0 mid-frame:** deassert En for 10 cycles mid-capture → outputs return to reset values. After re-enable, the first commit occurs only after sync + 8 channels + sync.
